// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: word, fetch FSM state, IF/ID latch
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int PC_INCR = 4;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic  valid;
        word_t instr;
        word_t pc;
        word_t npc;
    } ifid_t;

endpackage

// File: rtl/fetch_perf_cnt.sv
// rtl/fetch_perf_cnt.sv - saturating fetch/miss event counters (FETCH_PERF_EN builds only)
module fetch_perf_cnt
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  i_fetch_inc,
    input  logic  i_miss_inc,
    output word_t o_fetch_cnt,
    output word_t o_miss_cnt
);

    word_t r_fetch_cnt;
    word_t r_miss_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_fetch_cnt <= '0;
            r_miss_cnt  <= '0;
        end else begin
            if (i_fetch_inc && (r_fetch_cnt != '1))
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (i_miss_inc && (r_miss_cnt != '1))
                r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign o_fetch_cnt = r_fetch_cnt;
    assign o_miss_cnt  = r_miss_cnt;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, imem request and IF/ID latch; FETCH_PERF_EN adds counters
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000,
    parameter int    PC_INCR = 4
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  ihit,
    input  word_t imemload,
    output logic  imemREN,
    output word_t imemaddr,
    input  logic  pc_cntrl,
    input  word_t final_memaddr,
    input  logic  stall,
    input  logic  halt,
    output logic  ifid_valid,
    output word_t ifid_instr,
    output word_t ifid_pc,
    output word_t ifid_npc,
    output logic  halted
`ifdef FETCH_PERF_EN
    ,
    output word_t fetch_cnt,
    output word_t miss_cnt
`endif
);

    localparam word_t INCR_W = word_t'(PC_INCR);

    fetch_state_t r_state;
    word_t        r_pc;
    ifid_t        r_ifid;
    word_t        w_pc_seq;
    logic         w_fetching;

    assign w_pc_seq   = r_pc + INCR_W;
    assign w_fetching = (r_state == FETCH);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= BOOT;
            r_pc    <= PC_INIT;
            r_ifid  <= '0;
        end else begin
            case (r_state)
                BOOT: r_state <= FETCH;
                FETCH: begin
                    if (halt) begin
                        r_state      <= HALTED;
                        r_ifid.valid <= 1'b0;
                    end else if (pc_cntrl) begin
                        // Redirect squashes whatever returned this cycle, stall or not.
                        r_pc         <= {final_memaddr[31:2], 2'b00};
                        r_ifid.valid <= 1'b0;
                    end else if (stall) begin
                        r_pc   <= r_pc;
                        r_ifid <= r_ifid;
                    end else if (ihit) begin
                        r_pc         <= w_pc_seq;
                        r_ifid.valid <= 1'b1;
                        r_ifid.instr <= imemload;
                        r_ifid.pc    <= r_pc;
                        r_ifid.npc   <= w_pc_seq;
                    end else begin
                        r_ifid.valid <= 1'b0;
                    end
                end
                HALTED: r_ifid.valid <= 1'b0;
                default: r_state <= BOOT;
            endcase
        end
    end

    assign imemREN    = w_fetching;
    assign imemaddr   = r_pc;
    assign ifid_valid = r_ifid.valid;
    assign ifid_instr = r_ifid.instr;
    assign ifid_pc    = r_ifid.pc;
    assign ifid_npc   = r_ifid.npc;
    assign halted     = (r_state == HALTED);

`ifdef FETCH_PERF_EN
    logic w_fetch_inc;
    logic w_miss_inc;

    assign w_fetch_inc = w_fetching && !halt && !pc_cntrl && !stall && ihit;
    assign w_miss_inc  = w_fetching && !halt && !pc_cntrl && !ihit;

    fetch_perf_cnt u_perf (
        .CLK         (CLK),
        .nRST        (nRST),
        .i_fetch_inc (w_fetch_inc),
        .i_miss_inc  (w_miss_inc),
        .o_fetch_cnt (fetch_cnt),
        .o_miss_cnt  (miss_cnt)
    );
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline latch, directly upstream of the execute datapath.
- Owns the PC register, drives the instruction-memory read request, and applies redirects returned from execute (pc_cntrl / final_memaddr).
- Presents instruction, PC and PC+4 to decode; PC+4 travels down the pipe and becomes the execute stage's next_memaddr.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.
- PC_INCR, 4, byte increment per sequential fetch.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- ihit  in  1  instruction memory returned imemload this cycle.
- imemload  in  32  fetched instruction word.
- imemREN  out  1  instruction read enable.
- imemaddr  out  32  fetch address (current PC).
- pc_cntrl  in  1  redirect request from execute (already qualified with ihit upstream).
- final_memaddr  in  32  redirect target from execute.
- stall  in  1  hazard unit: hold PC and IF/ID.
- halt  in  1  halt committed at writeback.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_instr  out  32  latched instruction.
- ifid_pc  out  32  PC of the latched instruction.
- ifid_npc  out  32  ifid_pc + PC_INCR.
- halted  out  1  fetch permanently stopped.

Behaviour:
- Reset (async, nRST=0):
  - pc=PC_INIT; state=BOOT.
  - ifid_valid=0; ifid_instr/pc/npc=0.
  - imemREN=0; halted=0.
- States: BOOT, FETCH, HALTED.
  - BOOT: imemREN=0; unconditionally moves to FETCH on the next edge. Gives memory one quiet cycle.
  - FETCH: imemREN=1, imemaddr=pc, both combinational from the registered pc.
  - HALTED: imemREN=0, pc frozen, ifid_valid=0, halted=1. Left only through reset.
- Per-edge priority in FETCH, highest first:
  1. halt=1 → state=HALTED, ifid_valid<=0.
  2. pc_cntrl=1 → pc<={final_memaddr[31:2],2'b00}, ifid_valid<=0 (squash). Applies even when stall=1. An ihit on the same edge is discarded.
  3. stall=1 → pc and all IF/ID fields hold. An ihit this cycle is dropped and refetched later.
  4. ihit=1 → pc<=pc+PC_INCR; ifid_instr<=imemload, ifid_pc<=pc, ifid_npc<=pc+PC_INCR, ifid_valid<=1.
  5. otherwise (miss) → pc holds, ifid_valid<=0 (bubble). Other IF/ID fields hold.
- Latency: sequential fetch adds one instruction to IF/ID per ihit cycle. A redirect costs one bubble, and the new target appears on imemaddr the cycle after pc_cntrl.
- Arithmetic: 32-bit unsigned, modulo 2^32. pc=32'hFFFF_FFFC plus 4 gives 32'h0000_0000.
- Redirect during an outstanding miss: the old request is abandoned and imemaddr changes to the target the next cycle.
- halt and pc_cntrl together: halt wins.
- Reset mid-miss: returns to BOOT; no IF/ID update.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds outputs fetch_cnt[31:0] and miss_cnt[31:0].
  - fetch_cnt increments on each rule-4 edge.
  - miss_cnt increments on each FETCH cycle with imemREN=1, ihit=0, no halt and no pc_cntrl.
  - Both are 0 on reset, saturate at 32'hFFFF_FFFF, and freeze in HALTED.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- cpu_types_pkg gains:
  - fetch_state_t enum {BOOT, FETCH, HALTED}.
  - ifid_t packed struct {valid, instr, pc, npc}, all word_t except valid.
  - PC_INCR constant.
- The existing word_t is reused.
- One natural sub-module: fetch_perf_cnt (two saturating counters), instantiated only under FETCH_PERF_EN.

Test Plan:
- Reset with PC_INIT=0, ihit=1 every cycle → cycle 1 imemREN=0, cycle 2 imemaddr=0. IF/ID then shows pc 0,4,8 with npc 4,8,12 and valid=1.
- pc_cntrl=1 with final_memaddr=32'h0000_0102 → next imemaddr=32'h0000_0100, ifid_valid=0 for one cycle, then pc=0x100 latched.
- stall=1 for 3 cycles with ihit=1 and pc=0x20 → imemaddr stays 0x20, IF/ID unchanged. After release the 0x20 instruction is latched.
- ihit=0 for 4 cycles at pc=0x40, then pc_cntrl to 0x80 → ifid_valid=0 throughout, next imemaddr=0x80, 0x40 never latched. With FETCH_PERF_EN, miss_cnt=4.
- pc=32'hFFFF_FFFC with ihit → ifid_npc=0, next imemaddr=0.
- halt and pc_cntrl asserted together → halted=1, imemREN=0, pc unchanged. Later ihit or pc_cntrl have no effect until nRST.
